// File: rtl/crc_fault_pkg.sv
// crc_fault_pkg
// Shared types and constants for the CRC fault-injection engine.
//   fault_mode_e : fault applied to the data stream feeding the faulted CRC
//   state_e      : message FSM states
//   CCITT_POLY / CCITT_INIT : CRC-16-CCITT generator (top term omitted) and seed
package crc_fault_pkg;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        STUCK     = 2'd1,
        FLIP      = 2'd2,
        TRANSIENT = 2'd3
    } fault_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] CCITT_POLY = 16'h1021;
    localparam logic [15:0] CCITT_INIT = 16'hFFFF;

endpackage

// File: rtl/crc_fault_engine_crc_step.sv
// crc_step
// Combinational MSB-first CRC update over one DATA_W-bit beat.
// Ports:
//   crc_in  : current CRC register value
//   data    : beat to absorb, data[DATA_W-1] processed first
//   crc_out : CRC after all DATA_W bits have been absorbed
module crc_step #(
    parameter int              DATA_W = 16,
    parameter int              CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    always_comb begin
        logic [CRC_W-1:0] c;
        logic             fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = data[i] ^ c[CRC_W-1];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_fault_engine.sv
// crc_fault_engine
// Computes a golden CRC over an incoming message and, in parallel, a CRC over
// a fault-injected copy of the same data, then presents both for comparison.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   s_valid/s_ready     : message beat handshake
//   s_data, s_last      : beat payload and end-of-message marker
//   fault_mode/mask/value/beat : fault configuration, captured on first beat
//   m_valid/m_ready     : result handshake
//   m_crc, m_golden     : faulted and fault-free CRC (after XOR_OUT)
//   m_mismatch          : m_crc differs from m_golden
//   m_beats             : accepted beat count, saturating
module crc_fault_engine
    import crc_fault_pkg::*;
#(
    parameter int               DATA_W  = 16,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(CCITT_INIT),
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [1:0]        fault_mode,
    input  logic [DATA_W-1:0] fault_mask,
    input  logic [DATA_W-1:0] fault_value,
    input  logic [15:0]       fault_beat,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [CRC_W-1:0]  m_crc,
    output logic [CRC_W-1:0]  m_golden,
    output logic              m_mismatch,
    output logic [15:0]       m_beats
);

    state_e            state_q, state_d;
    logic [CRC_W-1:0]  crc_g_q, crc_f_q;
    logic [CRC_W-1:0]  crc_g_nxt, crc_f_nxt;
    logic [15:0]       beats_q;

    fault_mode_e       mode_q;
    logic [DATA_W-1:0] mask_q, value_q;
    logic [15:0]       fbeat_q;

    fault_mode_e       mode_eff;
    logic [DATA_W-1:0] mask_eff, value_eff;
    logic [15:0]       fbeat_eff;
    logic [DATA_W-1:0] d_f;

    logic accept;
    logic first_beat;
    logic release_result;

    assign s_ready        = (state_q != DONE);
    assign accept         = s_valid & s_ready;
    assign first_beat     = (state_q == IDLE);
    assign release_result = (state_q == DONE) & m_ready;

    // The first beat must already see the live configuration; the latched
    // copy only becomes visible from the second beat onward.
    assign mode_eff  = first_beat ? fault_mode_e'(fault_mode) : mode_q;
    assign mask_eff  = first_beat ? fault_mask  : mask_q;
    assign value_eff = first_beat ? fault_value : value_q;
    assign fbeat_eff = first_beat ? fault_beat  : fbeat_q;

    // beats_q counts beats already accepted, so it is the 0-based index of
    // the beat currently offered.
    always_comb begin
        d_f = s_data;
        case (mode_eff)
            NONE:      d_f = s_data;
            STUCK:     d_f = (s_data & ~mask_eff) | (value_eff & mask_eff);
            FLIP:      d_f = s_data ^ mask_eff;
            TRANSIENT: d_f = (beats_q == fbeat_eff) ? (s_data ^ mask_eff) : s_data;
            default:   d_f = s_data;
        endcase
    end

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step_golden (
        .crc_in  (crc_g_q),
        .data    (s_data),
        .crc_out (crc_g_nxt)
    );

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step_fault (
        .crc_in  (crc_f_q),
        .data    (d_f),
        .crc_out (crc_f_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = s_last ? DONE : RUN;
            RUN:  if (accept && s_last) state_d = DONE;
            DONE: if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            crc_g_q <= INIT;
            crc_f_q <= INIT;
            beats_q <= '0;
            mode_q  <= NONE;
            mask_q  <= '0;
            value_q <= '0;
            fbeat_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                crc_g_q <= crc_g_nxt;
                crc_f_q <= crc_f_nxt;
                if (beats_q != 16'hFFFF) beats_q <= beats_q + 16'd1;
                if (first_beat) begin
                    mode_q  <= fault_mode_e'(fault_mode);
                    mask_q  <= fault_mask;
                    value_q <= fault_value;
                    fbeat_q <= fault_beat;
                end
            end
            if (release_result) begin
                crc_g_q <= INIT;
                crc_f_q <= INIT;
                beats_q <= '0;
            end
        end
    end

    always_comb begin
        m_valid    = 1'b0;
        m_crc      = '0;
        m_golden   = '0;
        m_mismatch = 1'b0;
        m_beats    = '0;
        if (state_q == DONE) begin
            m_valid    = 1'b1;
            m_crc      = crc_f_q ^ XOR_OUT;
            m_golden   = crc_g_q ^ XOR_OUT;
            m_mismatch = (crc_f_q ^ XOR_OUT) != (crc_g_q ^ XOR_OUT);
            m_beats    = beats_q;
        end
    end

endmodule

// File: tb/tb_crc_fault_engine.sv
module tb_crc_fault_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 16-bit data instance
    logic        s_valid = 0, s_last = 0, m_ready = 0;
    logic [15:0] s_data = 0, fault_mask = 0, fault_value = 0, fault_beat = 0;
    logic [1:0]  fault_mode = 0;
    logic        s_ready, m_valid, m_mismatch;
    logic [15:0] m_crc, m_golden, m_beats;

    // 8-bit data instance
    logic        s8_valid = 0, s8_last = 0, m8_ready = 0;
    logic [7:0]  s8_data = 0, f8_mask = 0, f8_value = 0;
    logic [15:0] f8_beat = 0;
    logic [1:0]  f8_mode = 0;
    logic        s8_ready, m8_valid, m8_mismatch;
    logic [15:0] m8_crc, m8_golden, m8_beats;

    int checks = 0;
    int failures = 0;

    crc_fault_engine u_dut16 (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fault_mode(fault_mode), .fault_mask(fault_mask),
        .fault_value(fault_value), .fault_beat(fault_beat),
        .m_ready(m_ready), .m_valid(m_valid), .m_crc(m_crc),
        .m_golden(m_golden), .m_mismatch(m_mismatch), .m_beats(m_beats)
    );

    crc_fault_engine #(.DATA_W(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s8_data), .s_last(s8_last),
        .fault_mode(f8_mode), .fault_mask(f8_mask),
        .fault_value(f8_value), .fault_beat(f8_beat),
        .m_ready(m8_ready), .m_valid(m8_valid), .m_crc(m8_crc),
        .m_golden(m8_golden), .m_mismatch(m8_mismatch), .m_beats(m8_beats)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bitwise CRC-16-CCITT over the low w bits of d, MSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d, input int w);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = w - 1; i >= 0; i--) begin
            fb = d[i] ^ r[15];
            r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    task automatic beat16(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release16(input string tag);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk({tag, "_mvalid_low"}, m_valid, 1'b0);
        chk({tag, "_sready_high"}, s_ready, 1'b1);
    endtask

    logic [7:0]  msg [9];
    logic [15:0] tmsg [4];
    logic [15:0] g, f;

    initial begin
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        tmsg = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

        // reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_mcrc", m_crc, 16'h0000);
        chk("rst_mgolden", m_golden, 16'h0000);
        chk("rst_mbeats", m_beats, 16'h0000);
        chk("rst_m8valid", m8_valid, 1'b0);

        // "123456789" on the 8-bit instance, mode NONE
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("c8_mvalid_before_last", m8_valid, 1'b0);
            s8_valid = 1'b1;
            s8_data  = msg[i];
            s8_last  = (i == 8);
            @(posedge clk); #1;
        end
        s8_valid = 1'b0;
        s8_last  = 1'b0;
        chk("c8_mvalid", m8_valid, 1'b1);
        chk("c8_sready_done", s8_ready, 1'b0);
        chk("c8_mcrc", m8_crc, 16'h29B1);
        chk("c8_mgolden", m8_golden, 16'h29B1);
        chk("c8_mismatch", m8_mismatch, 1'b0);
        chk("c8_mbeats", m8_beats, 16'd9);
        m8_ready = 1'b1;
        @(posedge clk); #1;
        m8_ready = 1'b0;
        chk("c8_release", m8_valid, 1'b0);

        // STUCK bit 0 at 1, single beat 0x0000 (IDLE -> DONE directly)
        fault_mode = 2'd1; fault_mask = 16'h0001; fault_value = 16'h0001;
        beat16(16'h0000, 1'b1);
        chk("stk_mvalid", m_valid, 1'b1);
        chk("stk_mgolden", m_golden, 16'h1D0F);
        chk("stk_mcrc", m_crc, 16'h0D2E);
        chk("stk_mismatch", m_mismatch, 1'b1);
        chk("stk_mbeats", m_beats, 16'd1);

        // hold result with m_ready low while a beat is offered
        fault_mode = 2'd0; fault_mask = 16'h0000; fault_value = 16'h0000;
        s_valid = 1'b1; s_data = 16'hFFFF; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_sready", s_ready, 1'b0);
            chk("hold_mcrc", m_crc, 16'h0D2E);
        end
        chk("hold_mgolden", m_golden, 16'h1D0F);
        chk("hold_mbeats", m_beats, 16'd1);
        s_valid = 1'b0; s_last = 1'b0;
        release16("hold");

        // next message restarts from INIT
        beat16(16'h0000, 1'b1);
        chk("fresh_mgolden", m_golden, 16'h1D0F);
        chk("fresh_mcrc", m_crc, 16'h1D0F);
        chk("fresh_mismatch", m_mismatch, 1'b0);
        release16("fresh");

        // TRANSIENT on beat 2 of a 4-beat message
        fault_mode = 2'd3; fault_mask = 16'h00FF; fault_beat = 16'd2;
        g = 16'hFFFF; f = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            g = crc_ref(g, tmsg[i], 16);
            f = crc_ref(f, (i == 2) ? (tmsg[i] ^ 16'h00FF) : tmsg[i], 16);
            if (i == 3) chk("tr2_mvalid_before_last", m_valid, 1'b0);
            beat16(tmsg[i], i == 3);
        end
        chk("tr2_mvalid", m_valid, 1'b1);
        chk("tr2_mgolden", m_golden, g);
        chk("tr2_mcrc", m_crc, f);
        chk("tr2_mismatch", m_mismatch, 1'b1);
        chk("tr2_mbeats", m_beats, 16'd4);
        release16("tr2");

        // TRANSIENT on the last beat (boundary, index 3)
        fault_beat = 16'd3;
        for (int i = 0; i < 4; i++) beat16(tmsg[i], i == 3);
        chk("tr3_mismatch", m_mismatch, 1'b1);
        chk("tr3_mgolden", m_golden, g);
        release16("tr3");

        // TRANSIENT beyond the message length
        fault_beat = 16'd7;
        for (int i = 0; i < 4; i++) beat16(tmsg[i], i == 3);
        chk("tr7_mismatch", m_mismatch, 1'b0);
        chk("tr7_mcrc", m_crc, g);
        release16("tr7");

        // FLIP MSB on a single beat
        fault_mode = 2'd2; fault_mask = 16'h8000;
        beat16(16'h1234, 1'b1);
        chk("flip_mgolden", m_golden, crc_ref(16'hFFFF, 16'h1234, 16));
        chk("flip_mcrc", m_crc, crc_ref(16'hFFFF, 16'h9234, 16));
        chk("flip_mismatch", m_mismatch, 1'b1);
        release16("flip");

        // mask changed after the first beat has no effect on this message
        fault_mode = 2'd2; fault_mask = 16'h0001;
        beat16(16'h0000, 1'b0);
        fault_mask = 16'hFFFF; fault_mode = 2'd0;
        beat16(16'h0000, 1'b1);
        f = crc_ref(crc_ref(16'hFFFF, 16'h0001, 16), 16'h0001, 16);
        chk("latch_mcrc", m_crc, f);
        chk("latch_mgolden", m_golden, crc_ref(16'h1D0F, 16'h0000, 16));
        chk("latch_mbeats", m_beats, 16'd2);
        release16("latch");

        // reset mid-message, with a beat offered on the reset edge
        fault_mode = 2'd2; fault_mask = 16'h00F0;
        beat16(tmsg[0], 1'b0);
        beat16(tmsg[1], 1'b0);
        reset = 1'b1;
        s_valid = 1'b1; s_data = tmsg[2]; s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("rstmid_mvalid", m_valid, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_mvalid_after", m_valid, 1'b0);
        chk("rstmid_sready", s_ready, 1'b1);
        fault_mode = 2'd0; fault_mask = 16'h0000;
        beat16(16'h0000, 1'b1);
        chk("rstmid_mgolden", m_golden, 16'h1D0F);
        chk("rstmid_mcrc", m_crc, 16'h1D0F);
        chk("rstmid_mbeats", m_beats, 16'd1);
        release16("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
